// File: rtl/gprf_pkg.sv
// Shared types and helpers for the multi-port GPRF.
// Optional build macros: DAT_W (default data width), GPRF_PARITY_EN (per-register parity).
`ifndef DAT_W
`define DAT_W 16
`endif

package gprf_pkg;

  localparam int unsigned GPRF_DAT_W_DEF = `DAT_W;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned GPRF_MAX_DAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    DONE = 2'd2
  } gprf_state_e;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [GPRF_MAX_DAT_W-1:0] d);
    return ^d;
  endfunction

  // True when an ADDR_W-bit address can reach every register.
  function automatic bit addr_w_ok(input int unsigned aw, input int unsigned n);
    return (64'(1) << aw) >= 64'(n);
  endfunction

endpackage

// File: rtl/gprf_rd_port.sv
// One registered read port: decode, range check, write-through bypass, output register.
// Parity checking is present only when GPRF_PARITY_EN is defined.
module gprf_rd_port
  import gprf_pkg::*;
#(
  parameter int unsigned DAT_W  = GPRF_DAT_W_DEF,
  parameter int unsigned NREG   = 20,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DAT_W-1:0]  mem [NREG],
`ifdef GPRF_PARITY_EN
  input  logic [NREG-1:0]   mem_par,
  output logic              rd_perr,
`endif
  input  logic              byp_we,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DAT_W-1:0]  byp_dat,
  output logic [DAT_W-1:0]  rd_dat,
  output logic              rd_vld,
  output logic              rd_oor
);

  localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

  logic             in_rng;
  logic             hit;
  logic [DAT_W-1:0] sel_dat;
  logic [DAT_W-1:0] nxt_dat;
`ifdef GPRF_PARITY_EN
  logic             sel_par;
  logic             nxt_perr;
`endif

  // Select the addressed word, then let an in-flight write override it.
  always_comb begin
    in_rng  = {1'b0, rd_addr} < NREG_L;
    sel_dat = '0;
`ifdef GPRF_PARITY_EN
    sel_par = 1'b0;
`endif
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        sel_dat = mem[i];
`ifdef GPRF_PARITY_EN
        sel_par = mem_par[i];
`endif
      end
    end
    hit     = byp_we && (byp_addr == rd_addr);
    nxt_dat = !in_rng ? '0 : (hit ? byp_dat : sel_dat);
`ifdef GPRF_PARITY_EN
    nxt_perr = in_rng && !hit && (even_par(GPRF_MAX_DAT_W'(sel_dat)) != sel_par);
`endif
    rd_oor  = rd_en && !in_rng;
  end

  // Output register: data holds while idle, valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_dat  <= '0;
      rd_vld  <= 1'b0;
`ifdef GPRF_PARITY_EN
      rd_perr <= 1'b0;
`endif
    end else begin
      rd_vld  <= rd_en;
      if (rd_en) rd_dat <= nxt_dat;
`ifdef GPRF_PARITY_EN
      rd_perr <= rd_en && nxt_perr;
`endif
    end
  end

endmodule

// File: rtl/gprf_mp.sv
// Multi-port general-purpose register file: one write port, NRD registered read
// ports with bypass, hardware bulk clear, out-of-range access detection.
// Optional build macro: GPRF_PARITY_EN adds par_inj/rd_perr and per-register parity.
module gprf_mp
  import gprf_pkg::*;
#(
  parameter int unsigned DAT_W  = GPRF_DAT_W_DEF,
  parameter int unsigned NREG   = 20,
  parameter int unsigned NRD    = 2,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DAT_W-1:0]      wr_dat,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DAT_W-1:0]  rd_dat,
  output logic [NRD-1:0]        rd_vld,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
`ifdef GPRF_PARITY_EN
  input  logic                  par_inj,
  output logic [NRD-1:0]        rd_perr,
`endif
  output logic                  acc_err
);

  localparam bit              ADDR_W_OK = addr_w_ok(ADDR_W, NREG);
  localparam logic [ADDR_W:0] NREG_L    = (ADDR_W+1)'(NREG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG-1);

  if (!ADDR_W_OK) begin : g_cfg_err
    $error("gprf_mp: ADDR_W too narrow for NREG");
  end

  gprf_state_e       state;
  logic [ADDR_W-1:0] idx;
  logic [DAT_W-1:0]  regs [NREG];
  logic              wr_in_rng;
  logic              wr_bad;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DAT_W-1:0]  mem_wdat;
  logic [NRD-1:0]    rd_oor;
`ifdef GPRF_PARITY_EN
  logic [NREG-1:0]   par;
  logic              mem_wpar;
`endif

  // The clear sequencer owns the single storage write path while in CLR;
  // routing it through the same path lets reads bypass the zero being written.
  always_comb begin
    wr_in_rng = {1'b0, wr_addr} < NREG_L;
    wr_bad    = wr_en && (!wr_in_rng || (state == CLR));
    if (state == CLR) begin
      mem_we    = 1'b1;
      mem_waddr = idx;
      mem_wdat  = '0;
    end else begin
      mem_we    = wr_en && wr_in_rng;
      mem_waddr = wr_addr;
      mem_wdat  = wr_dat;
    end
`ifdef GPRF_PARITY_EN
    mem_wpar = (state == CLR) ? 1'b0 : (even_par(GPRF_MAX_DAT_W'(wr_dat)) ^ par_inj);
`endif
  end

  // Clear FSM: walk idx over every register, then pulse done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: if (clr_req) begin
          state <= CLR;
          idx   <= '0;
        end
        CLR: if (idx == LAST_IDX) state <= DONE;
             else                 idx   <= idx + 1'b1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array with decoded write.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef GPRF_PARITY_EN
      par <= '0;
`endif
    end else if (mem_we) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (mem_waddr == ADDR_W'(i)) begin
          regs[i] <= mem_wdat;
`ifdef GPRF_PARITY_EN
          par[i]  <= mem_wpar;
`endif
        end
      end
    end
  end

  // Single error pulse for any combination of bad write and bad reads.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) acc_err <= 1'b0;
    else        acc_err <= wr_bad || (|rd_oor);
  end

  assign clr_busy = (state == CLR);
  assign clr_done = (state == DONE);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    gprf_rd_port #(
      .DAT_W  (DAT_W),
      .NREG   (NREG),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .clk      (clk),
      .rst_b    (rst_b),
      .rd_en    (rd_en[k]),
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem      (regs),
`ifdef GPRF_PARITY_EN
      .mem_par  (par),
      .rd_perr  (rd_perr[k]),
`endif
      .byp_we   (mem_we),
      .byp_addr (mem_waddr),
      .byp_dat  (mem_wdat),
      .rd_dat   (rd_dat[k*DAT_W +: DAT_W]),
      .rd_vld   (rd_vld[k]),
      .rd_oor   (rd_oor[k])
    );
  end

endmodule

// File: tb/tb_gprf_mp.sv
// Scoreboard bench for gprf_mp: stimulus pushes expected read results,
// a monitor pops and compares whenever rd_vld is seen.
module tb_gprf_mp;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 20;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 5;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_dat = '0;
  logic [NP-1:0]    rd_en = '0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic [NP*DW-1:0] rd_dat;
  logic [NP-1:0]    rd_vld;
  logic             clr_req = 1'b0;
  logic             clr_busy;
  logic             clr_done;
  logic             acc_err;
  logic             par_inj = 1'b0;
`ifdef GPRF_PARITY_EN
  logic [NP-1:0]    rd_perr;
`endif

  gprf_mp #(.DAT_W(DW), .NREG(NR), .NRD(NP), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_dat   (rd_dat),
    .rd_vld   (rd_vld),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
`ifdef GPRF_PARITY_EN
    .par_inj  (par_inj),
    .rd_perr  (rd_perr),
`endif
    .acc_err  (acc_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          perr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare each valid read against the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (rd_vld[0]) begin
      if (q0.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL rd0_unexpected: got %h want none at %0t", rd_dat[DW-1:0], $time);
      end else begin
        e = q0.pop_front();
        chk("rd0_dat", 32'(rd_dat[DW-1:0]), 32'(e.dat));
`ifdef GPRF_PARITY_EN
        chk("rd0_perr", 32'(rd_perr[0]), 32'(e.perr));
`endif
      end
    end
    if (rd_vld[1]) begin
      if (q1.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL rd1_unexpected: got %h want none at %0t", rd_dat[2*DW-1:DW], $time);
      end else begin
        e = q1.pop_front();
        chk("rd1_dat", 32'(rd_dat[2*DW-1:DW]), 32'(e.dat));
`ifdef GPRF_PARITY_EN
        chk("rd1_perr", 32'(rd_perr[1]), 32'(e.perr));
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = '0;
    clr_req = 1'b0;
    par_inj = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_dat  = d;
  endtask

  task automatic rd(input int k, input int a, input logic [DW-1:0] d, input logic pe);
    exp_t e;
    e.dat  = d;
    e.perr = pe;
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = AW'(a);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_rd_vld", 32'(rd_vld), 32'(0));
    chk("rst_rd_dat", 32'(rd_dat), 32'(0));
    chk("rst_acc_err", 32'(acc_err), 32'(0));
    chk("rst_clr_busy", 32'(clr_busy), 32'(0));
    chk("rst_clr_done", 32'(clr_done), 32'(0));
    rst_b = 1'b1;
    step();

    // Write then read back with one-cycle latency
    wr(0, 16'h0001); step();
    rd(0, 0, 16'h0001, 1'b0); step();
    chk("t1_acc_err", 32'(acc_err), 32'(0));

    // Bypass: write and read the same register on both ports together
    wr(19, 16'h0003); rd(0, 19, 16'h0003, 1'b0); rd(1, 19, 16'h0003, 1'b0); step();
    rd(1, 19, 16'h0003, 1'b0); step();

    // Out-of-range write and read
    wr(21, 16'hFFFF); step();
    chk("t3_wr_acc_err", 32'(acc_err), 32'(1));
    step();
    chk("t3_acc_err_clear", 32'(acc_err), 32'(0));
    rd(0, 25, 16'h0000, 1'b0); step();
    chk("t3_rd_acc_err", 32'(acc_err), 32'(1));
    rd(0, 1, 16'h0000, 1'b0); rd(1, 0, 16'h0001, 1'b0); step();
    chk("t3_inrange_no_err", 32'(acc_err), 32'(0));

    // Fill and bulk clear
    for (int i = 0; i < 20; i++) begin
      wr(i, 16'hA5A5); step();
    end
    clr_req = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      chk("t4_clr_busy", 32'(clr_busy), 32'(1));
      chk("t4_clr_done_low", 32'(clr_done), 32'(0));
      if (i == 2) begin
        rd(0, 0, 16'h0000, 1'b0);
        rd(1, 19, 16'hA5A5, 1'b0);
      end
      if (i == 3) wr(15, 16'h1234);
      if (i == 4) chk("t4_drop_acc_err", 32'(acc_err), 32'(1));
      if (i == 5) begin
        chk("t4_acc_err_once", 32'(acc_err), 32'(0));
        clr_req = 1'b1;
      end
      step();
    end
    chk("t4_busy_end", 32'(clr_busy), 32'(0));
    chk("t4_done_pulse", 32'(clr_done), 32'(1));
    step();
    chk("t4_done_low", 32'(clr_done), 32'(0));
    chk("t4_idle_busy", 32'(clr_busy), 32'(0));
    for (int i = 0; i < 10; i++) begin
      rd(0, 2*i, 16'h0000, 1'b0);
      rd(1, 2*i+1, 16'h0000, 1'b0);
      step();
    end

    // Reset in the middle of a clear
    wr(10, 16'h55AA); step();
    wr(18, 16'h0F0F); step();
    rd(0, 10, 16'h55AA, 1'b0); step();
    clr_req = 1'b1; step();
    for (int i = 0; i < 7; i++) step();
    chk("t5_busy_before", 32'(clr_busy), 32'(1));
    rst_b = 1'b0;
    #1;
    chk("t5_busy_reset", 32'(clr_busy), 32'(0));
    step();
    rst_b = 1'b1;
    step();
    chk("t5_busy_after", 32'(clr_busy), 32'(0));
    rd(0, 10, 16'h0000, 1'b0); rd(1, 18, 16'h0000, 1'b0); step();
    step();
    chk("t5_no_restart", 32'(clr_busy), 32'(0));

`ifdef GPRF_PARITY_EN
    // Parity injection and bypass
    wr(5, 16'h0F0F); par_inj = 1'b1; step();
    rd(0, 5, 16'h0F0F, 1'b1); step();
    wr(5, 16'h0F0E); step();
    rd(0, 5, 16'h0F0E, 1'b0); step();
    wr(7, 16'h1111); par_inj = 1'b1; rd(1, 7, 16'h1111, 1'b0); step();
    rd(1, 7, 16'h1111, 1'b1); rd(0, 30, 16'h0000, 1'b0); step();
`endif

    step(); step(); step();
    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
